servo_pwm_driver: RTL and testbench
===================================

# servo_pwm_driver

Six-channel RC-servo PWM generator. It consumes the 72-bit packed servo-angle word that the control FSM forwards from the Plate Pose Controller, and drives one pulse-width-modulated output per servo. Angles are double-buffered and committed only at frame boundaries, so pulses never glitch. It sits between the control FSM's `pwm_angles` output and the FPGA pins driving the six plate servos.

## Interface
Parameters:
- `CLK_DIV`, 100: clocks per timing tick (1 µs at 100 MHz); must be ≥ 2.
- `FRAME_TICKS`, 20000: ticks per PWM frame (20 ms).
- `MIN_TICKS`, 1000: pulse width for angle 0.
- `SPAN_TICKS`, 1000: added width for full-scale angle (4096); `MIN_TICKS + SPAN_TICKS < FRAME_TICKS` is required.

Ports:
- `clock`, input, 1: sole clock; all logic is on its rising edge.
- `reset_n`, input, 1: asynchronous, active-low reset.
- `angles`, input, 72: six 12-bit unsigned angles; channel i occupies `[12*i+11:12*i]`.
- `angles_valid`, input, 1: single-cycle or level strobe; captures `angles` into the pending buffer.
- `enable`, input, 1: when low, all outputs are idle and counters are held.
- `pwm`, output, 6: servo pulses, bit i = channel i.
- `frame_start`, output, 1: one-cycle pulse marking the start of each frame.
- `update_ack`, output, 1: one-cycle pulse when pending angles are committed to the active widths.

## Operation
- **Prescaler** counts 0..`CLK_DIV`-1. `tick` is asserted when the count is `CLK_DIV`-1.
- **Frame counter** `frame_cnt` counts 0..`FRAME_TICKS`-1 and advances on `tick`. A **boundary** is a cycle with `tick` high and `frame_cnt == FRAME_TICKS-1`; the counter wraps to 0 on that edge.
- **Width map**: width_i = `MIN_TICKS` + ((angle_i × `SPAN_TICKS`) >> 12).
  - The product is computed at full width (12 + clog2(`SPAN_TICKS`+1) bits) and truncated, not rounded.
  - Width registers are clog2(`MIN_TICKS`+`SPAN_TICKS`+1) bits.
- **Capture**: on `angles_valid`, `pending_angles <= angles` and `pending_new <= 1`. Capture happens regardless of `enable`.
- **Commit**: when `pending_new` is set and either a boundary occurs or `enable` is low, then:
  - `active_width[i]` is loaded from the width map of `pending_angles`;
  - `pending_new` is cleared;
  - `update_ack` pulses.
- **Simultaneous capture and commit**: the commit uses the pre-edge `pending_angles`, the new word is captured, and `pending_new` stays 1. The new word commits at the next boundary.
- **Output**: `pwm[i] <= enable && (frame_cnt < active_width[i])`.
- **Enable low**: prescaler and `frame_cnt` are held at 0 and `pwm` is low.
  - On the first enabled cycle, a frame begins at `frame_cnt` = 0 and `frame_start` pulses.
- **Reset values**:
  - `pwm` = 0, `frame_start` = 0, `update_ack` = 0;
  - counters = 0, `pending_new` = 0;
  - `pending_angles` = 2048 per channel;
  - `active_width` = `MIN_TICKS` + `SPAN_TICKS`/2 (center).
- **Reset mid-frame**: `pwm` drops low immediately (asynchronously). Any uncommitted pending word is discarded.

## Timing
- `pwm` has one cycle of latency relative to `frame_cnt`. A pulse is high for exactly width × `CLK_DIV` clocks per frame.
- The frame period is exactly `FRAME_TICKS` × `CLK_DIV` clocks.
- `frame_start` is registered and goes high in the cycle after a boundary edge, coincident with the first high cycle of any nonzero-width `pwm`.
- `update_ack` is registered and goes high one cycle after the commit edge. A boundary commit therefore affects the frame that starts on that edge.
- Worst-case capture-to-output latency is one frame plus 2 cycles.

## Structure
- Shared package `servo_pwm_pkg` holds:
  - constants `NUM_SERVOS`=6, `ANGLE_W`=12, `ANGLE_CENTER`=2048;
  - function `angle_to_width`.
- The control FSM uses the same package for the packing of `angles`.
- Sub-module `servo_tick_gen` contains the prescaler and frame counter, and outputs `tick`, `boundary` and `frame_cnt`.
- The six comparators and the width registers are generated in a loop in the top module.

## Test plan
Bench parameters: `CLK_DIV`=4, `FRAME_TICKS`=100, `MIN_TICKS`=10, `SPAN_TICKS`=20. One frame is therefore 400 clocks.
- **Reset, enable=1, no `angles_valid`** → every `pwm` bit is high for 80 clocks (width 20) per 400-clock frame, and `frame_start` pulses every 400 clocks.
- **Angles {0, 4095, 2048, 1, 4094, 1024}, then wait for a boundary** → `update_ack` pulses once. In the next frame the `pwm` high times are 40, 116, 80, 40, 116 and 60 clocks.
- **Write 4095 to ch0 mid-frame (width currently 20)** → the current ch0 pulse stays at 80 clocks; the following frame gives 116 clocks.
- **Two `angles_valid` strobes in one frame (0, then 4095)** → only 4095 takes effect, with a single `update_ack`.
- **`angles_valid` on the exact boundary cycle** → the previous pending value commits and `update_ack` pulses. The new value commits at the next boundary with a second `update_ack`.
- **Drop `enable`, write angle 0, raise `enable`** → the commit occurs while disabled and `pwm` stays low. On the first enabled cycle `frame_start` pulses, and `pwm` is high for 40 clocks. Asserting `reset_n`=0 mid-pulse forces `pwm`=0 immediately.

Source files
------------

// File: rtl/servo_pwm_pkg.sv
// servo_pwm_pkg
//   Shared definitions for the six-channel servo PWM path: channel count,
//   angle format and the angle-to-pulse-width map. The control FSM packs
//   its angle word using the same constants.
//   Angle word layout: channel i occupies [ANGLE_W*i +: ANGLE_W].
package servo_pwm_pkg;

    localparam int NUM_SERVOS   = 6;
    localparam int ANGLE_W      = 12;
    localparam int ANGLE_CENTER = 2048;
    localparam int ANGLE_BUS_W  = NUM_SERVOS * ANGLE_W;

    // width = min_ticks + floor(angle * span_ticks / 2^ANGLE_W).
    // The 32-bit product covers 12 + clog2(span_ticks + 1) bits for any
    // practical span, so the shift truncates exactly like the narrow form.
    function automatic int angle_to_width(input logic [ANGLE_W-1:0] angle,
                                          input int                 min_ticks,
                                          input int                 span_ticks);
        logic [31:0] product;
        product = 32'(angle) * 32'(span_ticks);
        return min_ticks + int'(product >> ANGLE_W);
    endfunction

endpackage

// File: rtl/servo_tick_gen.sv
// servo_tick_gen
//   Timing base for the PWM frame: a prescaler dividing the clock down to
//   one tick every CLK_DIV clocks, and a frame counter of FRAME_TICKS ticks.
//   Both are held at zero while enable is low, so re-enabling always starts
//   a fresh frame.
// Ports:
//   clock, reset_n  - clock and asynchronous active-low reset
//   enable          - run the counters; low holds them at zero
//   tick            - high in the last prescaler cycle of each tick
//   boundary        - tick in the last tick of the frame (frame wraps here)
//   frame_cnt       - current tick index within the frame
module servo_tick_gen
    import servo_pwm_pkg::*;
#(
    parameter int CLK_DIV     = 100,
    parameter int FRAME_TICKS = 20000,
    parameter int CNT_W       = $clog2(FRAME_TICKS)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             enable,
    output logic             tick,
    output logic             boundary,
    output logic [CNT_W-1:0] frame_cnt
);

    localparam int PS_W = $clog2(CLK_DIV);

    logic [PS_W-1:0]  prescale_q,  prescale_d;
    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;

    assign tick      = enable && (prescale_q == PS_W'(CLK_DIV - 1));
    assign boundary  = tick && (frame_cnt_q == CNT_W'(FRAME_TICKS - 1));
    assign frame_cnt = frame_cnt_q;

    // NOTE: every always_comb output gets a default on entry so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        prescale_d  = prescale_q;
        frame_cnt_d = frame_cnt_q;
        if (!enable) begin
            prescale_d  = '0;
            frame_cnt_d = '0;
        end else begin
            prescale_d = tick ? '0 : prescale_q + 1'b1;
            if (boundary) begin
                frame_cnt_d = '0;
            end else if (tick) begin
                frame_cnt_d = frame_cnt_q + 1'b1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignment so every flop samples
    // the pre-edge values regardless of block ordering.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            prescale_q  <= '0;
            frame_cnt_q <= '0;
        end else begin
            prescale_q  <= prescale_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

endmodule

// File: rtl/servo_pwm_driver.sv
// servo_pwm_driver
//   Six-channel RC-servo PWM generator. New angle words are captured into a
//   pending buffer at any time and committed to the active pulse widths only
//   at a frame boundary (or immediately while disabled), so a pulse in
//   flight is never cut short or stretched.
// Ports:
//   clock, reset_n - clock and asynchronous active-low reset
//   angles         - six packed 12-bit angles, channel i at [12*i+11:12*i]
//   angles_valid   - capture strobe for angles
//   enable         - low forces pwm idle and holds the frame counters
//   pwm            - one pulse output per servo
//   frame_start    - one-cycle pulse, coincident with the first pulse cycle
//   update_ack     - one-cycle pulse one cycle after a commit
module servo_pwm_driver
    import servo_pwm_pkg::*;
#(
    parameter int CLK_DIV     = 100,
    parameter int FRAME_TICKS = 20000,
    parameter int MIN_TICKS   = 1000,
    parameter int SPAN_TICKS  = 1000
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic [ANGLE_BUS_W-1:0] angles,
    input  logic                   angles_valid,
    input  logic                   enable,
    output logic [NUM_SERVOS-1:0]  pwm,
    output logic                   frame_start,
    output logic                   update_ack
);

    localparam int CNT_W = $clog2(FRAME_TICKS);
    // MIN_TICKS + SPAN_TICKS < FRAME_TICKS, so a width always fits in CNT_W.
    localparam int W_W   = $clog2(MIN_TICKS + SPAN_TICKS + 1);

    logic             tick;
    logic             boundary;
    logic [CNT_W-1:0] frame_cnt;
    logic             commit;

    logic [ANGLE_BUS_W-1:0] pending_angles_q, pending_angles_d;
    logic                   pending_new_q,    pending_new_d;
    logic                   update_ack_q,     update_ack_d;
    logic                   frame_start_q,    frame_start_d;
    // Set while the counters sit at the very first clock of a frame.
    logic                   frame_head_q,     frame_head_d;

    servo_tick_gen #(
        .CLK_DIV     (CLK_DIV),
        .FRAME_TICKS (FRAME_TICKS),
        .CNT_W       (CNT_W)
    ) u_tick_gen (
        .clock     (clock),
        .reset_n   (reset_n),
        .enable    (enable),
        .tick      (tick),
        .boundary  (boundary),
        .frame_cnt (frame_cnt)
    );

    // A disabled driver has no pulse in flight, so it commits at once.
    assign commit = pending_new_q && (boundary || !enable);

    always_comb begin
        pending_angles_d = angles_valid ? angles : pending_angles_q;
        // A capture on the commit edge keeps the flag set: the commit takes
        // the old word and the new one waits for the next boundary.
        pending_new_d    = angles_valid || (pending_new_q && !commit);
        update_ack_d     = commit;
        // The counters return to the frame head when disabled or when the
        // last tick of the frame expires.
        frame_head_d     = !enable || (tick && frame_cnt == CNT_W'(FRAME_TICKS - 1));
        // Registered from the same counter state as pwm, so both rise together.
        frame_start_d    = enable && frame_head_q;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pending_angles_q <= {NUM_SERVOS{ANGLE_W'(ANGLE_CENTER)}};
            pending_new_q    <= 1'b0;
            update_ack_q     <= 1'b0;
            frame_start_q    <= 1'b0;
            frame_head_q     <= 1'b1;
        end else begin
            pending_angles_q <= pending_angles_d;
            pending_new_q    <= pending_new_d;
            update_ack_q     <= update_ack_d;
            frame_start_q    <= frame_start_d;
            frame_head_q     <= frame_head_d;
        end
    end

    assign update_ack  = update_ack_q;
    assign frame_start = frame_start_q;

    // Per-channel width register and comparator.
    for (genvar i = 0; i < NUM_SERVOS; i++) begin : g_ch
        logic [W_W-1:0] active_width_q, active_width_d;
        logic           pwm_q, pwm_d;

        always_comb begin
            active_width_d = active_width_q;
            if (commit) begin
                active_width_d = W_W'(angle_to_width(
                    pending_angles_q[ANGLE_W*i +: ANGLE_W], MIN_TICKS, SPAN_TICKS));
            end
            pwm_d = enable && (frame_cnt < CNT_W'(active_width_q));
        end

        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                active_width_q <= W_W'(MIN_TICKS + SPAN_TICKS / 2);
                pwm_q          <= 1'b0;
            end else begin
                active_width_q <= active_width_d;
                pwm_q          <= pwm_d;
            end
        end

        assign pwm[i] = pwm_q;
    end

endmodule

// File: tb/tb_servo_pwm_driver.sv
// tb_servo_pwm_driver
//   Directed bench for servo_pwm_driver with CLK_DIV=4, FRAME_TICKS=100,
//   MIN_TICKS=10, SPAN_TICKS=20 (400-clock frames). Pulse high times are
//   counted per channel over whole frames aligned on frame_start.
module tb_servo_pwm_driver;

    localparam int CLK_DIV     = 4;
    localparam int FRAME_TICKS = 100;
    localparam int MIN_TICKS   = 10;
    localparam int SPAN_TICKS  = 20;
    localparam int FRAME_CLKS  = CLK_DIV * FRAME_TICKS;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [71:0] angles;
    logic        angles_valid;
    logic        enable;
    logic [5:0]  pwm;
    logic        frame_start;
    logic        update_ack;

    int checks = 0;
    int errors = 0;

    servo_pwm_driver #(
        .CLK_DIV     (CLK_DIV),
        .FRAME_TICKS (FRAME_TICKS),
        .MIN_TICKS   (MIN_TICKS),
        .SPAN_TICKS  (SPAN_TICKS)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .angles       (angles),
        .angles_valid (angles_valid),
        .enable       (enable),
        .pwm          (pwm),
        .frame_start  (frame_start),
        .update_ack   (update_ack)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Wait (bounded) for frame_start on a falling edge; lat = edges waited.
    task automatic wait_fs(output int lat);
        lat = -1;
        for (int n = 1; n <= 3 * FRAME_CLKS; n++) begin
            @(negedge clock);
            if (frame_start === 1'b1) begin
                lat = n;
                break;
            end
        end
    endtask

    // Entered on the falling edge where frame_start is high; counts one full
    // frame and leaves on the next frame's frame_start edge. Up to two
    // angles_valid strobes are driven at frame cycles s1 and s2 (-1 = none).
    // exp_hi holds expected high clocks, channel i in [8*i +: 8].
    task automatic measure(input string tag, input logic [47:0] exp_hi,
                           input int exp_ack,
                           input int s1, input logic [71:0] w1,
                           input int s2, input logic [71:0] w2);
        int hi[6];
        int fs;
        int ack;
        fs  = 0;
        ack = 0;
        for (int i = 0; i < 6; i++) hi[i] = 0;
        for (int c = 0; c < FRAME_CLKS; c++) begin
            if (c == s1) begin
                angles = w1;
                angles_valid = 1'b1;
            end else if (c == s2) begin
                angles = w2;
                angles_valid = 1'b1;
            end else begin
                angles_valid = 1'b0;
            end
            for (int i = 0; i < 6; i++) hi[i] += int'(pwm[i]);
            fs  += int'(frame_start);
            ack += int'(update_ack);
            @(negedge clock);
        end
        angles_valid = 1'b0;
        for (int i = 0; i < 6; i++)
            check($sformatf("%s_ch%0d_high", tag, i), hi[i], int'(exp_hi[8*i +: 8]));
        check({tag, "_frame_start_count"}, fs, 1);
        check({tag, "_ack_count"}, ack, exp_ack);
        check({tag, "_period"}, int'(frame_start), 1);
    endtask

    initial begin
        int lat;
        int hi_all;
        int ack;
        int fs;

        reset_n      = 1'b0;
        enable       = 1'b1;
        angles_valid = 1'b0;
        angles       = '0;

        repeat (3) @(negedge clock);
        check("reset_pwm", int'(pwm), 0);
        check("reset_frame_start", int'(frame_start), 0);
        check("reset_update_ack", int'(update_ack), 0);

        reset_n = 1'b1;
        wait_fs(lat);
        check("first_frame_latency", lat, 1);

        // Centre widths; a mid-frame ch0 write leaves this frame alone.
        measure("center", {6{8'd80}}, 1,
                150, {{5{12'd2048}}, 12'd4095}, -1, '0);
        // ch0 now full scale; load the mixed pattern.
        measure("ch0_full", {{5{8'd80}}, 8'd116}, 1,
                100, {12'd1024, 12'd4094, 12'd1, 12'd2048, 12'd4095, 12'd0}, -1, '0);
        // Mixed pattern visible; two strobes, only the last must commit.
        measure("mixed", {8'd60, 8'd116, 8'd40, 8'd80, 8'd116, 8'd40}, 1,
                50, 72'd0, 200, {6{12'd4095}});
        // All full scale; a strobe lands on the boundary cycle itself.
        measure("double", {6{8'd116}}, 1,
                100, 72'd0, FRAME_CLKS - 2, {6{12'd1024}});
        // Older pending word committed; boundary-cycle word still pending.
        measure("bnd_old", {6{8'd40}}, 1, -1, '0, -1, '0);
        measure("bnd_new", {6{8'd60}}, 0, -1, '0, -1, '0);

        // Disabled: a write commits at once while pwm stays idle.
        enable = 1'b0;
        @(negedge clock);
        hi_all = 0;
        ack    = 0;
        fs     = 0;
        for (int c = 0; c < 12; c++) begin
            angles       = '0;
            angles_valid = (c == 2);
            hi_all += $countones(pwm);
            ack    += int'(update_ack);
            fs     += int'(frame_start);
            @(negedge clock);
        end
        angles_valid = 1'b0;
        check("disabled_pwm_high", hi_all, 0);
        check("disabled_ack_count", ack, 1);
        check("disabled_frame_start", fs, 0);

        enable = 1'b1;
        wait_fs(lat);
        check("reenable_latency", lat, 1);
        measure("reenable", {6{8'd40}}, 0, -1, '0, -1, '0);

        // Reset in the middle of a pulse with a word pending.
        repeat (8) @(negedge clock);
        angles       = {6{12'd4095}};
        angles_valid = 1'b1;
        @(negedge clock);
        angles_valid = 1'b0;
        check("pre_reset_pwm", int'(pwm), 63);
        #2 reset_n = 1'b0;
        #1;
        check("async_reset_pwm", int'(pwm), 0);
        check("async_reset_ack", int'(update_ack), 0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        wait_fs(lat);
        check("post_reset_latency", lat, 1);
        measure("post_reset", {6{8'd80}}, 0, -1, '0, -1, '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
